y_operand_fetch: RTL and testbench
==================================

Name: y_operand_fetch

Overview:
- Operand-fetch stage directly upstream of the 16-bit ALU.
- Holds the register file and a pending-write scoreboard that stalls read-after-write hazards.
- Each accepted instruction is latched into an output register, which presents a, b and op to the ALU over a valid/ready handshake.
- Write-back from downstream returns through a dedicated write port.

Parameters:
- WIDTH, 16, datapath width; must match the ALU operand width.
- NREG, 8, number of architectural registers; r0 is hardwired zero.
- AW, 3, register address width; log2(NREG).
- OPW, 3, ALU op field width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_rs1  in  AW  source register for a.
- in_rs2  in  AW  source register for b.
- in_rd  in  AW  destination register.
- in_wen  in  1  instruction will write in_rd.
- in_imm  in  WIDTH  immediate.
- in_use_imm  in  1  b = in_imm instead of reg[rs2].
- in_op  in  OPW  ALU op, passed through.
- wb_en  in  1  write-back strobe.
- wb_addr  in  AW  write-back register.
- wb_data  in  WIDTH  write-back value.
- out_valid  out  1  a/b/alu_op/out_rd/out_wen valid.
- out_ready  in  1  ALU side consumes this cycle.
- a  out  WIDTH  ALU operand a.
- b  out  WIDTH  ALU operand b.
- alu_op  out  OPW  ALU op.
- out_rd  out  AW  destination carried to write-back.
- out_wen  out  1  write flag carried to write-back.

Behaviour:
- Reset, one cycle, synchronous:
  - all registers cleared to 0 and every pending bit cleared;
  - out_valid=0; a, b, alu_op, out_rd and out_wen all 0.
  - rst overrides every simultaneous input, including wb_en and in_valid.
  - An instruction held in the output register when rst asserts is discarded.
- Register file:
  - write at the clock edge when wb_en=1 and wb_addr!=0;
  - writes to r0 are ignored; reads of r0 return 0.
- Read and bypass, combinational:
  - src(x) = 0 if x==0;
  - else wb_data if wb_en and wb_addr==x;
  - else reg[x].
  - b source is in_imm when in_use_imm=1, otherwise src(in_rs2).
- Scoreboard:
  - pend[NREG-1:0], with pend[0] always 0.
  - eff_pend = pend with bit wb_addr cleared when wb_en=1.
  - hazard = eff_pend[in_rs1] | (eff_pend[in_rs2] & !in_use_imm).
  - Next pend = eff_pend, then set bit in_rd if the instruction is accepted with in_wen=1 and in_rd!=0. Set wins over a same-cycle clear of the same address.
- Handshake:
  - in_ready = !hazard & (!out_valid | out_ready).
  - Accept = in_valid & in_ready. On accept, the output register captures a, b, in_op, in_rd and in_wen, and out_valid is set to 1 the next cycle.
  - out_valid is cleared on out_ready & !accept.
  - While out_valid=1 and out_ready=0, all outputs hold stable. A held output is never refreshed by a later write-back.
- Latency and throughput:
  - one cycle from accept to out_valid;
  - full throughput of one instruction per cycle when no hazard and out_ready=1.
- in_ready depends combinationally on in_rs1, in_rs2 and in_use_imm. Upstream must hold its fields stable while in_valid=1 and in_ready=0.
- wb_en for a register with no pending bit is legal: it writes the register and leaves the scoreboard unchanged.

Decomposition:
- Shared package holds:
  - WIDTH, AW, NREG and OPW;
  - ALU op encodings: AND=3'b000, OR=3'b001, ADD=3'b010, SUB=3'b110, SLT=3'b111.
- One natural sub-module, y_regfile: NREG x WIDTH storage, two combinational read ports with write bypass, one write port, r0 hardwired zero, synchronous reset clear.
- The scoreboard, handshake and output register stay in the top.

Test Plan:
- Reset then read: after rst, in_rs1=3, in_rs2=5, in_op=ADD, in_valid=1 -> next cycle out_valid=1, a=0, b=0, alu_op=3'b010.
- Write/read and r0 rules:
  - wb_en, wb_addr=2, wb_data=16'h1234, then read rs1=2 with use_imm and imm=16'h0007 -> a=16'h1234, b=16'h0007.
  - wb to r0 with 16'hFFFF, then read r0 -> 0.
- RAW stall and bypass:
  - accept rd=4 with wen=1; next instruction with rs1=4 -> in_ready=0.
  - Stall lasts until wb_en, wb_addr=4, wb_data=16'hBEEF; in that same cycle in_ready=1, accept, and next cycle a=16'hBEEF.
- Backpressure: out_ready=0 for 3 cycles with a new instruction waiting -> in_ready=0 and a, b, alu_op unchanged; on out_ready=1 the next instruction is captured the following cycle.
- Simultaneous set/clear: pend[6]=1; same cycle wb_addr=6 and accept of rd=6, wen=1 -> pend[6] remains 1, and a following rs2=6 stalls.
- Mid-operation reset: out_valid=1, out_ready=0 and pend[3]=1, then assert rst -> next cycle out_valid=0, pend all 0, reg[2] reads 0, and in_ready=1 for rs1=3.

Source files
------------

// File: rtl/y_operand_fetch_pkg.sv
// Shared sizes and ALU op encodings for the operand-fetch stage and its register file.
package y_operand_fetch_pkg;

  localparam int WIDTH = 16;
  localparam int NREG  = 8;
  localparam int AW    = 3;
  localparam int OPW   = 3;

  typedef enum logic [OPW-1:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

endpackage

// File: rtl/y_regfile.sv
// NREG x WIDTH register file: two combinational read ports that see a same-cycle
// write-back, one write port, r0 hardwired to zero.
module y_regfile
  import y_operand_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2
);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (wen && waddr != '0) regs_d[waddr] = wdata;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  always_comb begin
    rdata1 = regs_q[raddr1];
    rdata2 = regs_q[raddr2];
    if (wen && waddr == raddr1) rdata1 = wdata;
    if (wen && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == '0) rdata1 = '0;
    if (raddr2 == '0) rdata2 = '0;
  end

endmodule

// File: rtl/y_operand_fetch.sv
// Operand-fetch stage: register read with write-back bypass, pending-write
// scoreboard for RAW stalls, and a valid/ready output register toward the ALU.
module y_operand_fetch
  import y_operand_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic [AW-1:0]    in_rd,
  input  logic             in_wen,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic [OPW-1:0]   in_op,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [OPW-1:0]   alu_op,
  output logic [AW-1:0]    out_rd,
  output logic             out_wen
);

  logic [WIDTH-1:0] src_a, src_b;
  logic [NREG-1:0]  pend_q, pend_d, eff_pend;
  logic             hazard, accept;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic             wen_q, wen_d;

  y_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .wen    (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (in_rs1),
    .raddr2 (in_rs2),
    .rdata1 (src_a),
    .rdata2 (src_b)
  );

  // A write-back landing this cycle releases its pending bit before the hazard check.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      eff_pend[i] = pend_q[i] & ~(wb_en & (wb_addr == AW'(i)));
    end
    hazard   = eff_pend[in_rs1] | (eff_pend[in_rs2] & ~in_use_imm);
    in_ready = ~hazard & (~valid_q | out_ready);
    accept   = in_valid & in_ready;

    pend_d = eff_pend;
    if (accept && in_wen && in_rd != '0) pend_d[in_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
    if (accept) begin
      valid_d = 1'b1;
      a_d     = src_a;
      b_d     = in_use_imm ? in_imm : src_b;
      op_d    = in_op;
      rd_d    = in_rd;
      wen_d   = in_wen;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
    end
  end

  assign out_valid = valid_q;
  assign a         = a_q;
  assign b         = b_q;
  assign alu_op    = op_q;
  assign out_rd    = rd_q;
  assign out_wen   = wen_q;

endmodule

// File: tb/tb_y_operand_fetch.sv
// Scoreboard bench for y_operand_fetch: a behavioural model predicts accepts and
// operands; a separate monitor compares whatever the stage presents downstream.
module tb_y_operand_fetch;
  import y_operand_fetch_pkg::*;

  logic             clk, rst;
  logic             in_valid, in_ready;
  logic [AW-1:0]    in_rs1, in_rs2, in_rd;
  logic             in_wen, in_use_imm;
  logic [WIDTH-1:0] in_imm;
  logic [OPW-1:0]   in_op;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] a, b;
  logic [OPW-1:0]   alu_op;
  logic [AW-1:0]    out_rd;
  logic             out_wen;

  y_operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_op(in_op),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .alu_op(alu_op), .out_rd(out_rd), .out_wen(out_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
    logic [AW-1:0]    rd;
    logic             wen;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: architectural registers, set of registers awaiting write-back,
  // and whether an instruction is sitting in the output slot.
  logic [WIDTH-1:0] m_regs [NREG];
  logic             m_pend [NREG];
  logic             m_full;
  logic             m_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_src(input int x);
    if (x == 0) return '0;
    if (wb_en && int'(wb_addr) == x) return wb_data;
    return m_regs[x];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_full  = 1'b0;
    m_ready = 1'b1;
  endtask

  // Inputs are set at posedge+1; the model is evaluated at the following negedge.
  task automatic step();
    bit   busy1, busy2, stall, acc;
    exp_t e;
    @(negedge clk);
    if (rst) begin
      m_reset();
      q.delete();
    end else begin
      busy1 = m_pend[in_rs1] && !(wb_en && wb_addr == in_rs1);
      busy2 = m_pend[in_rs2] && !(wb_en && wb_addr == in_rs2) && !in_use_imm;
      stall = busy1 || busy2 || (m_full && !out_ready);
      m_ready = !stall;
      chk("in_ready", in_ready, m_ready);
      chk("out_valid", out_valid, m_full);
      acc = in_valid && m_ready;
      if (acc) begin
        e.a   = m_src(int'(in_rs1));
        e.b   = in_use_imm ? in_imm : m_src(int'(in_rs2));
        e.op  = in_op;
        e.rd  = in_rd;
        e.wen = in_wen;
        q.push_back(e);
      end
      if (wb_en) m_pend[wb_addr] = 1'b0;
      if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
      if (acc && in_wen && in_rd != 0) m_pend[in_rd] = 1'b1;
      if (acc) m_full = 1'b1;
      else if (out_ready) m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: the presented slot must match the oldest predicted instruction,
  // every cycle it is held, and is retired when the ALU takes it.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_unexpected: got out_valid=1 expected nothing pending (t=%0t)", $time);
      end else begin
        chk("out_a", a, q[0].a);
        chk("out_b", b, q[0].b);
        chk("out_op", alu_op, q[0].op);
        chk("out_rd", out_rd, q[0].rd);
        chk("out_wen", out_wen, q[0].wen);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic set_instr(input logic v, input int rs1, input int rs2, input int rd,
                           input logic wen, input logic use_imm, input logic [WIDTH-1:0] imm,
                           input logic [OPW-1:0] op);
    in_valid   = v;
    in_rs1     = AW'(rs1);
    in_rs2     = AW'(rs2);
    in_rd      = AW'(rd);
    in_wen     = wen;
    in_use_imm = use_imm;
    in_imm     = imm;
    in_op      = op;
  endtask

  task automatic set_wb(input logic en, input int addr, input logic [WIDTH-1:0] data);
    wb_en   = en;
    wb_addr = AW'(addr);
    wb_data = data;
  endtask

  logic [WIDTH-1:0] hold_a, hold_b;
  logic [OPW-1:0]   hold_op;

  initial begin
    m_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    set_instr(1'b1, 7, 7, 7, 1'b1, 1'b0, 16'hAAAA, OP_SUB);
    set_wb(1'b1, 5, 16'h5555);
    step();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_wen", out_wen, 0);

    // read after reset
    set_wb(1'b0, 0, '0);
    set_instr(1'b1, 3, 5, 0, 1'b0, 1'b0, '0, OP_ADD);
    step();
    chk("rr_valid", out_valid, 1);
    chk("rr_a", a, 0);
    chk("rr_b", b, 0);
    chk("rr_op", alu_op, 3'b010);

    // write then read with immediate
    set_instr(1'b0, 0, 0, 0, 1'b0, 1'b0, '0, OP_AND);
    set_wb(1'b1, 2, 16'h1234);
    step();
    set_wb(1'b0, 0, '0);
    set_instr(1'b1, 2, 0, 0, 1'b0, 1'b1, 16'h0007, OP_OR);
    step();
    chk("wr_a", a, 16'h1234);
    chk("wr_b", b, 16'h0007);

    // r0 stays zero
    set_instr(1'b0, 0, 0, 0, 1'b0, 1'b0, '0, OP_AND);
    set_wb(1'b1, 0, 16'hFFFF);
    step();
    set_wb(1'b0, 0, '0);
    set_instr(1'b1, 0, 0, 0, 1'b0, 1'b0, '0, OP_AND);
    step();
    chk("r0_a", a, 0);
    chk("r0_b", b, 0);

    // RAW stall resolved by a bypassed write-back
    set_instr(1'b1, 1, 1, 4, 1'b1, 1'b0, '0, OP_ADD);
    step();
    set_instr(1'b1, 4, 0, 0, 1'b0, 1'b0, '0, OP_SLT);
    #1 chk("raw_stall", in_ready, 0);
    step();
    step();
    set_wb(1'b1, 4, 16'hBEEF);
    #1 chk("raw_release", in_ready, 1);
    step();
    set_wb(1'b0, 0, '0);
    chk("raw_bypass_a", a, 16'hBEEF);

    // backpressure
    set_instr(1'b1, 2, 0, 0, 1'b0, 1'b1, 16'h00C3, OP_AND);
    step();
    hold_a = a; hold_b = b; hold_op = alu_op;
    out_ready = 1'b0;
    set_instr(1'b1, 0, 2, 0, 1'b0, 1'b0, '0, OP_SUB);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", in_ready, 0);
      step();
      chk("bp_hold_a", a, hold_a);
      chk("bp_hold_b", b, hold_b);
      chk("bp_hold_op", alu_op, hold_op);
    end
    out_ready = 1'b1;
    step();
    chk("bp_new_op", alu_op, OP_SUB);
    chk("bp_new_b", b, 16'h1234);

    // pending set wins over same-cycle clear
    set_instr(1'b1, 0, 0, 6, 1'b1, 1'b1, '0, OP_OR);
    step();
    set_wb(1'b1, 6, 16'h0055);
    step();
    set_wb(1'b0, 0, '0);
    set_instr(1'b1, 0, 6, 0, 1'b0, 1'b0, '0, OP_ADD);
    #1 chk("setclr_stall", in_ready, 0);
    step();
    set_wb(1'b1, 6, 16'h0066);
    step();
    set_wb(1'b0, 0, '0);
    chk("setclr_b", b, 16'h0066);

    // reset while an instruction is held and r3 is pending
    set_instr(1'b0, 0, 0, 0, 1'b0, 1'b0, '0, OP_AND);
    step();
    set_instr(1'b1, 0, 0, 3, 1'b1, 1'b1, 16'h0001, OP_ADD);
    step();
    set_instr(1'b0, 0, 0, 0, 1'b0, 1'b0, '0, OP_AND);
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("mr_out_valid", out_valid, 0);
    set_instr(1'b0, 3, 0, 0, 1'b0, 1'b1, '0, OP_AND);
    #1 chk("mr_ready_r3", in_ready, 1);
    set_instr(1'b1, 2, 2, 0, 1'b0, 1'b0, '0, OP_AND);
    step();
    chk("mr_r2_a", a, 0);
    chk("mr_r2_b", b, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (!(in_valid && !m_ready)) begin
        set_instr($urandom_range(0, 3) != 0, $urandom_range(0, NREG - 1),
                  $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                  WIDTH'($urandom), OPW'($urandom));
      end
      set_wb($urandom_range(0, 2) == 0, $urandom_range(0, NREG - 1), WIDTH'($urandom));
      out_ready = $urandom_range(0, 3) != 0;
      step();
    end

    // drain
    set_instr(1'b0, 0, 0, 0, 1'b0, 1'b0, '0, OP_AND);
    set_wb(1'b0, 0, '0);
    out_ready = 1'b1;
    step();
    step();
    chk("drain_queue", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
